vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller. Generates pixel tick, pixel coordinates, sync pulses and frame/line markers for any mode set by parameters. Adds programmable clock divide, sync polarity, run enable, line/frame start pulses and a frame counter. Sits between the board clock and the pixel/graphics generators.

---
 rtl/vga_timing_gen.sv | 80 ++++++++
 tb/tb_vga_timing_gen.sv | 99 +++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with pixel tick, syncs, line/frame markers and frame counter
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HR = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VR = 2,
  parameter int VB = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int CW = 10,
  parameter int FCW = 16
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  input  logic           enable,
  output logic           p_tick,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           video_on,
  output logic           hsync,
  output logic           vsync,
  output logic           vblank,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HD_C = CW'(HD);
  localparam logic [CW-1:0] HS0 = CW'(HD + HF);
  localparam logic [CW-1:0] HS1 = CW'(HD + HF + HR);
  localparam logic [CW-1:0] HTOT_M1 = CW'(HD + HF + HR + HB - 1);
  localparam logic [CW-1:0] VD_C = CW'(VD);
  localparam logic [CW-1:0] VS0 = CW'(VD + VF);
  localparam logic [CW-1:0] VS1 = CW'(VD + VF + VR);
  localparam logic [CW-1:0] VTOT_M1 = CW'(VD + VF + VR + VB - 1);
  logic run, x_end, y_end, start;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] nx, ny;
  // run marks timing already under way; its absence turns the next enabled clk into a restart at (0,0)
  always_comb begin
    p_tick = run && div_cnt == DIV_M1;
    x_end = x == HTOT_M1;
    y_end = y == VTOT_M1;
    start = enable && !run;
    nx = !run ? '0 : p_tick ? (x_end ? '0 : x + 1'b1) : x;
    ny = !run ? '0 : (p_tick && x_end) ? (y_end ? '0 : y + 1'b1) : y;
  end
  always_ff @(posedge clk_100MHz) begin
    if (reset || !enable) begin
      run <= 1'b0;
      div_cnt <= '0;
      x <= '0;
      y <= '0;
      video_on <= 1'b0;
      vblank <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      if (reset) frame_count <= '0;
    end else begin
      run <= 1'b1;
      div_cnt <= (!run || p_tick) ? '0 : div_cnt + 1'b1;
      x <= nx;
      y <= ny;
      video_on <= nx < HD_C && ny < VD_C;
      vblank <= ny >= VD_C;
      hsync <= (nx >= HS0 && nx < HS1) ? HSYNC_POL : ~HSYNC_POL;
      vsync <= (ny >= VS0 && ny < VS1) ? VSYNC_POL : ~VSYNC_POL;
      line_start <= start || (p_tick && x_end);
      frame_start <= start || (p_tick && x_end && y_end);
      if (p_tick && x_end && y_end) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized enable/reset stimulus, arithmetic raster model, queued scoreboard
module tb_vga_timing_gen;
  localparam int CD = 3, HD = 8, HF = 2, HR = 3, HB = 2, VD = 4, VF = 1, VR = 2, VB = 1;
  localparam int HT = HD + HF + HR + HB, VT = VD + VF + VR + VB, FRM = CD * HT * VT;
  localparam int CW = 4, FCW = 2;
  localparam logic HSP = 1'b1, VSP = 1'b0;
  typedef struct {
    logic pt, vo, hs, vs, vb, ls, fs;
    logic [CW-1:0] x, y;
    logic [FCW-1:0] fc;
  } exp_t;
  logic clk = 0, reset = 1, enable = 0;
  logic p_tick, video_on, hsync, vsync, vblank, line_start, frame_start;
  logic [CW-1:0] x, y;
  logic [FCW-1:0] frame_count;
  exp_t q[$];
  int checks = 0, failures = 0;
  vga_timing_gen #(.CLK_DIV(CD), .HD(HD), .HF(HF), .HR(HR), .HB(HB), .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .HSYNC_POL(HSP), .VSYNC_POL(VSP), .CW(CW), .FCW(FCW)) dut (
    .clk_100MHz(clk), .reset(reset), .enable(enable), .p_tick(p_tick), .x(x), .y(y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync), .vblank(vblank),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // t counts clks since timing (re)started; everything else follows from division of t
  bit on = 0;
  int t = 0, fc = 0;
  always @(posedge clk) begin
    exp_t e;
    int p, px, py;
    if (reset) begin on = 0; fc = 0; end
    else if (!enable) on = 0;
    else if (!on) begin on = 1; t = 0; end
    else begin
      t++;
      if (t % FRM == 0) fc = (fc + 1) % (1 << FCW);
    end
    e.fc = FCW'(fc);
    if (!on) begin
      e.pt = 0; e.x = '0; e.y = '0; e.vo = 0; e.vb = 0; e.ls = 0; e.fs = 0; e.hs = !HSP; e.vs = !VSP;
    end else begin
      p = t / CD; px = p % HT; py = (p / HT) % VT;
      e.pt = (t % CD) == CD - 1;
      e.x = CW'(px); e.y = CW'(py);
      e.vo = px < HD && py < VD;
      e.vb = py >= VD;
      e.hs = (px >= HD + HF && px < HD + HF + HR) ? HSP : !HSP;
      e.vs = (py >= VD + VF && py < VD + VF + VR) ? VSP : !VSP;
      e.ls = t % (CD * HT) == 0;
      e.fs = t % FRM == 0;
    end
    q.push_back(e);
  end
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() == 0) chk("queue_empty", 1, 0);
    else begin
      e = q.pop_front();
      chk("p_tick", 32'(p_tick), 32'(e.pt));
      chk("x", 32'(x), 32'(e.x));
      chk("y", 32'(y), 32'(e.y));
      chk("video_on", 32'(video_on), 32'(e.vo));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("vblank", 32'(vblank), 32'(e.vb));
      chk("line_start", 32'(line_start), 32'(e.ls));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("frame_count", 32'(frame_count), 32'(e.fc));
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    for (int s = 0; s < 14; s++) begin
      enable = 1;
      repeat (s == 0 ? 1600 : $urandom_range(20, 1500)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        reset = 1;
        enable = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 0;
      end else begin
        enable = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
